noc_node_tx: RTL and testbench

- Per-node transmit network interface. It sits between a node's traffic generator and one `pkt_in[i]` port of the NoC wrapper.
- Buffers generated packets in an injection FIFO and stamps each one with source ID and injection time.
- Presents the head packet with `valid` and retires it only on the network's enable. This implements the valid/enable injection side of the NoC protocol.
- Keeps saturating sent/dropped statistics for the emulation host.

---
 rtl/noc_node_tx_pkg.sv | 28 ++
 rtl/noc_tx_fifo.sv | 71 +++++++
 rtl/noc_node_tx.sv | 95 +++++++++
 tb/tb_noc_node_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_node_tx_pkg.sv
// =============================================================================
// Module   : noc_node_tx_pkg
// Purpose  : Shared NoC widths and packet format for the node transmit path.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package noc_node_tx_pkg;

    localparam int PORTS  = 16;
    localparam int DEST_W = $clog2(PORTS);
    localparam int DATA_W = 8;
    localparam int TS_W   = 8;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] source;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   timestamp;
        logic              measure;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

endpackage

`default_nettype wire

// File: rtl/noc_tx_fifo.sv
// =============================================================================
// Module   : noc_tx_fifo
// Purpose  : Synchronous FIFO with separate count so full/empty stay distinct.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module noc_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    // Full is judged on registered count only: a same-cycle pop never frees a slot.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/noc_node_tx.sv
// =============================================================================
// Module   : noc_node_tx
// Purpose  : Node transmit interface: stamps, queues and injects packets.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module noc_node_tx
    import noc_node_tx_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gen_valid,
    input  logic [DEST_W-1:0]      gen_dest,
    input  logic [DATA_W-1:0]      gen_data,
    input  logic                   gen_measure,
    output logic                   gen_full,
    output packet_t                pkt_out,
    input  logic                   net_en,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       tx_count,
    output logic [CNT_W-1:0]       drop_count
);

    localparam logic [DEST_W-1:0] SOURCE_ID = DEST_W'(NODE_ID);

    logic [TS_W-1:0]  r_time;
    logic [CNT_W-1:0] r_tx_count;
    logic [CNT_W-1:0] r_drop_count;

    packet_t          w_entry;
    logic [PKT_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_xfer;
    logic             w_drop;

    always_comb begin
        w_entry           = '0;
        w_entry.valid     = 1'b1;
        w_entry.source    = SOURCE_ID;
        w_entry.dest      = gen_dest;
        w_entry.data      = gen_data;
        w_entry.timestamp = r_time;
        w_entry.measure   = gen_measure;
    end

    noc_tx_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gen_valid),
        .pop   (net_en),
        .wdata (w_entry),
        .rdata (w_head),
        .count (occupancy),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_xfer = net_en && !w_empty;
    assign w_drop = gen_valid && w_full;

    // Empty FIFO presents an all-zero packet so stale storage never leaks out.
    assign pkt_out  = w_empty ? '0 : packet_t'(w_head);
    assign gen_full = w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time       <= '0;
            r_tx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            r_time <= r_time + TS_W'(1);
            if (w_xfer && (r_tx_count != '1)) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign tx_count   = r_tx_count;
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_noc_node_tx.sv
// =============================================================================
// Module   : tb_noc_node_tx
// Purpose  : Scoreboard bench for noc_node_tx, plus a narrow-counter instance.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_noc_node_tx;
    import noc_node_tx_pkg::*;

    localparam int DEPTH = 4;
    localparam int NODE  = 3;
    localparam int SAT_W = 2;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              gen_valid;
    logic [DEST_W-1:0] gen_dest;
    logic [DATA_W-1:0] gen_data;
    logic              gen_measure;
    logic              net_en;

    logic              gen_full;
    packet_t           pkt_out;
    logic [2:0]        occupancy;
    logic [31:0]       tx_count;
    logic [31:0]       drop_count;

    logic              s_gen_full;
    packet_t           s_pkt_out;
    logic [2:0]        s_occupancy;
    logic [SAT_W-1:0]  s_tx_count;
    logic [SAT_W-1:0]  s_drop_count;

    noc_node_tx #(.NODE_ID(NODE), .DEPTH(DEPTH), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .gen_valid(gen_valid), .gen_dest(gen_dest),
        .gen_data(gen_data), .gen_measure(gen_measure), .gen_full(gen_full),
        .pkt_out(pkt_out), .net_en(net_en), .occupancy(occupancy),
        .tx_count(tx_count), .drop_count(drop_count)
    );

    noc_node_tx #(.NODE_ID(NODE), .DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .gen_valid(gen_valid), .gen_dest(gen_dest),
        .gen_data(gen_data), .gen_measure(gen_measure), .gen_full(s_gen_full),
        .pkt_out(s_pkt_out), .net_en(net_en), .occupancy(s_occupancy),
        .tx_count(s_tx_count), .drop_count(s_drop_count)
    );

    always #5 clk = ~clk;

    packet_t         q[$];
    int              exp_tx;
    int              exp_drop;
    logic [TS_W-1:0] m_time;
    int              checks = 0;
    int              passed = 0;
    int              fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    task automatic check_state();
        packet_t exp_p;
        exp_p = (q.size() != 0) ? q[0] : '0;
        chk("pkt_out",     64'(pkt_out),      64'(exp_p));
        chk("occupancy",   64'(occupancy),    64'(q.size()));
        chk("gen_full",    64'(gen_full),     64'(q.size() == DEPTH));
        chk("tx_count",    64'(tx_count),     64'(exp_tx));
        chk("drop_count",  64'(drop_count),   64'(exp_drop));
        chk("sat_tx",      64'(s_tx_count),   64'(sat(exp_tx)));
        chk("sat_drop",    64'(s_drop_count), 64'(sat(exp_drop)));
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic cycle(input logic gv, input int dest, input int data,
                         input logic meas, input logic en);
        int sz;
        gen_valid   = gv;
        gen_dest    = DEST_W'(dest);
        gen_data    = DATA_W'(data);
        gen_measure = meas;
        net_en      = en;
        check_state();
        sz = q.size();
        if (en && sz != 0) begin
            void'(q.pop_front());
            exp_tx++;
        end
        if (gv) begin
            if (sz == DEPTH) exp_drop++;
            else q.push_back('{valid: 1'b1, source: DEST_W'(NODE), dest: DEST_W'(dest),
                               data: DATA_W'(data), timestamp: m_time, measure: meas});
        end
        m_time++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        gen_valid = 1'b0;
        net_en    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_tx   = 0;
        exp_drop = 0;
        m_time   = '0;
        check_state();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        gen_dest = '0; gen_data = '0; gen_measure = 1'b0;

        // Reset then idle with net_en high
        do_reset();
        repeat (10) cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Single packet offered at time 5
        do_reset();
        repeat (5) cycle(1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 7, 'hAB, 1'b1, 1'b1);
        chk("single_valid",  64'(pkt_out.valid),     64'd1);
        chk("single_source", 64'(pkt_out.source),    64'd3);
        chk("single_ts",     64'(pkt_out.timestamp), 64'd5);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("single_gone",   64'(pkt_out.valid),     64'd0);
        chk("single_tx",     64'(tx_count),          64'd1);

        // Back-pressure: six offers into a four-entry FIFO
        do_reset();
        for (int i = 1; i <= 6; i++) cycle(1'b1, i, 'h10 + i, i[0], 1'b0);
        chk("bp_occ",  64'(occupancy),    64'd4);
        chk("bp_full", 64'(gen_full),     64'd1);
        chk("bp_drop", 64'(drop_count),   64'd2);
        chk("bp_head", 64'(pkt_out.data), 64'h11);
        repeat (4) cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("bp_tx",   64'(tx_count),     64'd4);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Steady push/pop stream
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, i % 16, i * 7, 1'b0, 1'b1);
        chk("stream_occ",  64'(occupancy),  64'd1);
        chk("stream_tx",   64'(tx_count),   64'd19);
        chk("stream_drop", 64'(drop_count), 64'd0);

        // Full plus pop plus push in one cycle
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, i, 'h40 + i, 1'b0, 1'b0);
        cycle(1'b1, 9, 'h99, 1'b1, 1'b1);
        chk("fpp_drop", 64'(drop_count), 64'd1);
        chk("fpp_occ",  64'(occupancy),  64'd3);

        // Reset with three packets queued
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, i, 'h60 + i, 1'b0, 1'b0);
        do_reset();
        chk("rst_valid", 64'(pkt_out.valid), 64'd0);
        chk("rst_occ",   64'(occupancy),     64'd0);
        cycle(1'b1, 5, 'h77, 1'b0, 1'b0);
        chk("rst_ts0",   64'(pkt_out.timestamp), 64'd0);
        repeat (4) cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Timestamp wrap
        do_reset();
        repeat ((1 << TS_W) + 2) cycle(1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 2, 'h5A, 1'b0, 1'b0);
        chk("wrap_ts", 64'(pkt_out.timestamp), 64'd2);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);

        // Drop counter saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, i % 16, i, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
